// File: rtl/tick_irq_pkg.sv
// Shared types and constants for the periodic tick interrupt controller.
// Build option TICK_IRQ_CTRL_PRESCALE_EN adds a clock prescaler in front of the counter.
package tick_irq_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-PRESCALE strobe generator with synchronous clear.
// Only instantiated when TICK_IRQ_CTRL_PRESCALE_EN is defined.
module tick_prescaler #(
   parameter int PRESCALE = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic strobe
);

   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [W-1:0] cnt;

   assign strobe = (cnt == W'(PRESCALE - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || strobe)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/tick_irq_ctrl.sv
// Programmable periodic interrupt source feeding ei_req of the MCU.
// Define TICK_IRQ_CTRL_PRESCALE_EN to count prescaled ticks instead of clk cycles.
module tick_irq_ctrl
   import tick_irq_pkg::*;
#(
   parameter int PERIOD_W       = 16,
   parameter int DEFAULT_PERIOD = 6250,
`ifdef TICK_IRQ_CTRL_PRESCALE_EN
   parameter int PRESCALE       = 50,
`endif
   parameter int OVR_W          = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                cfg_enable,
   input  logic                irq_mask,
   input  logic                irq_ack,
   output logic                ei_req,
   output logic                tick,
   output logic                pending,
   output logic [OVR_W-1:0]    overrun_count,
   output logic [PERIOD_W-1:0] cycle_count
);

   state_t              state, state_next;
   logic [PERIOD_W-1:0] period_reg;
   logic [PERIOD_W-1:0] counter;
   logic [PERIOD_W-1:0] period_in;
   logic                running;
   logic                advance;
   logic                pre_strobe;
   logic                wrap;
   logic                pending_next;

`ifdef TICK_IRQ_CTRL_PRESCALE_EN
   logic pre_clear;

   // Holding the prescaler clear while off restarts it on leaving ST_OFF.
   assign pre_clear = (state == ST_OFF) || cfg_we;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (pre_clear),
      .strobe (pre_strobe)
   );
`else
   assign pre_strobe = 1'b1;
`endif

   assign period_in = (cfg_period < PERIOD_W'(MIN_PERIOD)) ?
                      PERIOD_W'(MIN_PERIOD) : cfg_period;

   assign advance      = running && cfg_enable && !cfg_we;
   assign wrap         = advance && pre_strobe &&
                         (counter == period_reg - 1'b1);
   assign pending_next = wrap || (pending && !irq_ack);

   assign cycle_count = counter;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_OFF;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_OFF:
            if (cfg_enable)
               state_next = pending_next ? ST_PEND : ST_RUN;
         ST_RUN:
            if (!cfg_enable)
               state_next = ST_OFF;
            else if (wrap)
               state_next = ST_PEND;
         ST_PEND:
            if (!cfg_enable)
               state_next = ST_OFF;
            else if (!pending_next)
               state_next = ST_RUN;
         default:
            state_next = ST_OFF;
      endcase
   end

   always_comb begin
      running = (state != ST_OFF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_reg <= PERIOD_W'(DEFAULT_PERIOD);
         counter    <= '0;
      end else begin
         if (cfg_we)
            period_reg <= period_in;
         if (!advance)
            counter <= '0;
         else if (pre_strobe)
            counter <= wrap ? '0 : counter + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick          <= 1'b0;
         pending       <= 1'b0;
         ei_req        <= 1'b0;
         overrun_count <= '0;
      end else begin
         tick    <= wrap;
         pending <= pending_next;
         ei_req  <= pending && !irq_mask;
         // A tick landing on an unacked pending is lost; ack on the same edge rescues it.
         if (wrap && pending && !irq_ack && (overrun_count != '1))
            overrun_count <= overrun_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_tick_irq_ctrl.sv
// Self-checking bench for tick_irq_ctrl: vector table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_tick_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [15:0] cfg_period;
   logic        cfg_enable;
   logic        irq_mask;
   logic        irq_ack;
   logic        ei_req;
   logic        tick;
   logic        pending;
   logic [7:0]  overrun_count;
   logic [15:0] cycle_count;

   int n_chk  = 0;
   int n_fail = 0;

   int m_per, m_cnt, m_ovr;
   bit m_pend, m_on, m_tick, m_ei;

   typedef struct {
      logic        we;
      logic [15:0] per;
      logic        en;
      logic        mask;
      logic        ack;
      logic        e_tick;
      logic        e_pend;
      logic        e_ei;
      logic [7:0]  e_ovr;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[22];

   always #5 clk = ~clk;

   tick_irq_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_we        (cfg_we),
      .cfg_period    (cfg_period),
      .cfg_enable    (cfg_enable),
      .irq_mask      (irq_mask),
      .irq_ack       (irq_ack),
      .ei_req        (ei_req),
      .tick          (tick),
      .pending       (pending),
      .overrun_count (overrun_count),
      .cycle_count   (cycle_count)
   );

   function automatic vec_t mk(input logic we, input int per,
                               input logic en, input logic mask,
                               input logic ack, input logic t,
                               input logic p, input logic e,
                               input int ovr, input int cnt);
      vec_t v;
      v.we = we; v.per = 16'(per); v.en = en; v.mask = mask;
      v.ack = ack; v.e_tick = t; v.e_pend = p; v.e_ei = e;
      v.e_ovr = 8'(ovr); v.e_cnt = 16'(cnt);
      return v;
   endfunction

   function automatic logic [31:0] dut_bundle();
      return {5'd0, tick, pending, ei_req, overrun_count, cycle_count};
   endfunction

   function automatic logic [31:0] mdl_bundle();
      return {5'd0, m_tick, m_pend, m_ei, 8'(m_ovr), 16'(m_cnt)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_per = 6250; m_cnt = 0; m_ovr = 0;
      m_pend = 0; m_on = 0; m_tick = 0; m_ei = 0;
   endtask

   // One clock edge of behaviour, from the currently applied inputs.
   task automatic m_step();
      bit wrap;
      wrap = 0;
      m_ei = m_pend && !irq_mask;
      if (cfg_we) begin
         m_per = (cfg_period < 2) ? 2 : int'(cfg_period);
         m_cnt = 0;
      end else if (!cfg_enable || !m_on) begin
         m_cnt = 0;
      end else begin
         wrap  = (m_cnt == m_per - 1);
         m_cnt = (m_cnt + 1) % m_per;
      end
      if (wrap) begin
         if (m_pend && !irq_ack && m_ovr < 255)
            m_ovr++;
         m_pend = 1;
      end else if (irq_ack) begin
         m_pend = 0;
      end
      m_tick = wrap;
      m_on   = cfg_enable;
   endtask

   task automatic drv(input logic we, input int per, input logic en,
                      input logic mask, input logic ack);
      cfg_we = we; cfg_period = 16'(per); cfg_enable = en;
      irq_mask = mask; irq_ack = ack;
   endtask

   task automatic cyc();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drv(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_reset();
   endtask

   // Cycles from the current point until the next tick, bounded.
   task automatic gap_to_tick(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!tick && n < 7000);
   endtask

   initial begin
      int n;
      int ticks;
      int g;

      reset = 1'b0;
      drv(0, 0, 0, 0, 0);
      #1 reset = 1'b1;
      #12;
      chk("reset_state", dut_bundle(), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_reset();

      tbl[0]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2);
      tbl[4]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 1);
      tbl[6]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 2);
      tbl[7]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      tbl[8]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1);
      tbl[9]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 2);
      tbl[10] = mk(0, 0, 1, 0, 1, 1, 1, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      tbl[17] = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      tbl[18] = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 1);
      tbl[19] = mk(0, 0, 1, 0, 0, 1, 1, 1, 1, 0);
      tbl[20] = mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 1);
      tbl[21] = mk(1, 5, 1, 0, 0, 0, 1, 1, 1, 0);

      for (int i = 0; i < 22; i++) begin
         drv(tbl[i].we, int'(tbl[i].per), tbl[i].en,
             tbl[i].mask, tbl[i].ack);
         cyc();
         chk($sformatf("vec%0d", i), dut_bundle(),
             {5'd0, tbl[i].e_tick, tbl[i].e_pend, tbl[i].e_ei,
              tbl[i].e_ovr, tbl[i].e_cnt});
      end

      // Default period after reset, ei_req one cycle behind tick.
      do_reset();
      drv(0, 0, 1, 0, 0);
      cyc();
      gap_to_tick(n);
      chk("first_tick_gap", 32'(n), 32'd6250);
      chk("ei_at_tick", {31'd0, ei_req}, 32'd0);
      cyc();
      chk("ei_after_tick", {31'd0, ei_req}, 32'd1);
      drv(0, 0, 1, 0, 1);
      cyc();
      drv(0, 0, 1, 0, 0);
      gap_to_tick(n);
      chk("second_tick_gap", 32'(n + 2), 32'd6250);
      chk("ovr_acked", 32'(overrun_count), 32'd0);

      // Unacked ticks accumulate overruns and saturate.
      do_reset();
      drv(1, 4, 1, 0, 0);
      cyc();
      drv(0, 0, 1, 0, 0);
      ticks = 0;
      g = 0;
      while (ticks < 5 && g < 100) begin
         cyc();
         g++;
         if (tick) ticks++;
      end
      chk("ovr_after5", 32'(overrun_count), 32'd4);
      chk("pend_after5", {31'd0, pending}, 32'd1);
      while (ticks < 300 && g < 2000) begin
         cyc();
         g++;
         if (tick) ticks++;
      end
      chk("ticks_300", 32'(ticks), 32'd300);
      chk("ovr_sat", 32'(overrun_count), 32'd255);

      // Asynchronous reset while pending and ei_req are high.
      #3 reset = 1'b1;
      #1;
      chk("async_reset", dut_bundle(), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_reset();
      drv(0, 0, 1, 0, 0);
      cyc();
      gap_to_tick(n);
      chk("period_restored", 32'(n), 32'd6250);

      // Randomized traffic against the model.
      do_reset();
      drv(1, 6, 1, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         cyc();
         chk("rand", dut_bundle(), mdl_bundle());
         cfg_we     = ($urandom_range(0, 49) == 0);
         cfg_period = 16'($urandom_range(0, 9));
         if ($urandom_range(0, 99) == 0) cfg_enable = ~cfg_enable;
         if ($urandom_range(0, 19) == 0) irq_mask = ~irq_mask;
         irq_ack    = ($urandom_range(0, 5) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
